// File: rtl/calc_pkg.sv
// calc_pkg: shared state encoding, op codes and BCD digit width for the calculator key entry
package calc_pkg;
  localparam int BCD_W = 4;
  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    SEL_OP  = 3'd1,
    ENTER_B = 3'd2,
    REQ     = 3'd3,
    WAIT    = 3'd4,
    SHOW    = 3'd5
  } state_e;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;
endpackage

// File: rtl/bcd_digit_step.sv
// bcd_digit_step: one BCD digit incremented (inc=1) or decremented (inc=0), wrapping 9<->0
// Ports: digit in, inc selects direction, next_digit out.
module bcd_digit_step
  import calc_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  input  logic             inc,
  output logic [BCD_W-1:0] next_digit
);
  always_comb
    next_digit = inc ? ((digit == 4'd9) ? 4'd0 : digit + 4'd1)
                     : ((digit == 4'd0) ? 4'd9 : digit - 4'd1);
endmodule

// File: rtl/calc_key_entry.sv
// calc_key_entry: builds BCD operands from debounced button pulses, hands them to the ALU, shows the result
// Ports: clk/rst_n; up/down/next/op/eq/clr pulses in; calc_valid/calc_ready handshake with
// operand_a/operand_b/op_code out; res_valid/res_bcd in; disp_bcd, digit_sel, state_o out.
module calc_key_entry
  import calc_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int OPS = 4,
  localparam int DSW = $clog2(DIGITS),
  localparam int W = BCD_W * DIGITS
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           up_pulse,
  input  logic           down_pulse,
  input  logic           next_pulse,
  input  logic           op_pulse,
  input  logic           eq_pulse,
  input  logic           clr_pulse,
  output logic           calc_valid,
  input  logic           calc_ready,
  output logic [W-1:0]   operand_a,
  output logic [W-1:0]   operand_b,
  output logic [1:0]     op_code,
  input  logic           res_valid,
  input  logic [W-1:0]   res_bcd,
  output logic [W-1:0]   disp_bcd,
  output logic [DSW-1:0] digit_sel,
  output logic [2:0]     state_o
);
  localparam logic [DSW-1:0] SEL_LAST = DSW'(DIGITS - 1);
  localparam logic [1:0] OP_LAST = 2'(OPS - 1);
  state_e state_q, state_d;
  logic [W-1:0] entry_q, entry_d, operand_a_q, operand_a_d, operand_b_q, operand_b_d;
  logic [W-1:0] result_q, result_d, disp_q, disp_d;
  logic [1:0] op_code_q, op_code_d;
  logic [DSW-1:0] digit_sel_q, digit_sel_d;
  logic calc_valid_q, calc_valid_d;
  logic [BCD_W-1:0] cur_digit, stepped;
  logic ev_clr, ev_eq, ev_op, ev_next, ev_up, ev_dn;
  // Only the highest-priority pulse of a cycle becomes an event, even if the state ignores it.
  assign ev_clr  = clr_pulse;
  assign ev_eq   = eq_pulse & ~clr_pulse;
  assign ev_op   = op_pulse & ~(eq_pulse | clr_pulse);
  assign ev_next = next_pulse & ~(op_pulse | eq_pulse | clr_pulse);
  assign ev_up   = up_pulse & ~(next_pulse | op_pulse | eq_pulse | clr_pulse);
  assign ev_dn   = down_pulse & ~(up_pulse | next_pulse | op_pulse | eq_pulse | clr_pulse);
  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < DIGITS; i++)
      if (i == int'(digit_sel_q)) cur_digit = entry_q[i*BCD_W +: BCD_W];
  end
  bcd_digit_step u_step (
    .digit      (cur_digit),
    .inc        (ev_up),
    .next_digit (stepped)
  );
  always_comb begin
    state_d      = state_q;
    entry_d      = entry_q;
    operand_a_d  = operand_a_q;
    operand_b_d  = operand_b_q;
    result_d     = result_q;
    op_code_d    = op_code_q;
    digit_sel_d  = digit_sel_q;
    calc_valid_d = calc_valid_q;
    disp_d = (state_q == ENTER_A || state_q == ENTER_B) ? entry_q
           : (state_q == SEL_OP) ? operand_a_q
           : (state_q == REQ || state_q == WAIT) ? operand_b_q
           : result_q;
    if (ev_clr) begin
      state_d      = ENTER_A;
      entry_d      = '0;
      operand_a_d  = '0;
      operand_b_d  = '0;
      result_d     = '0;
      op_code_d    = OP_ADD;
      digit_sel_d  = '0;
      calc_valid_d = 1'b0;
    end else begin
      case (state_q)
        ENTER_A, ENTER_B: begin
          if (ev_up || ev_dn)
            for (int i = 0; i < DIGITS; i++)
              if (i == int'(digit_sel_q)) entry_d[i*BCD_W +: BCD_W] = stepped;
          if (ev_next) digit_sel_d = (digit_sel_q == SEL_LAST) ? '0 : digit_sel_q + 1'b1;
          if (ev_op && state_q == ENTER_A) begin
            operand_a_d = entry_q;
            entry_d     = '0;
            digit_sel_d = '0;
            state_d     = SEL_OP;
          end
          if (ev_eq && state_q == ENTER_B) begin
            operand_b_d  = entry_q;
            calc_valid_d = 1'b1;
            state_d      = REQ;
          end
        end
        SEL_OP: begin
          op_code_d = ev_up ? ((op_code_q == OP_LAST) ? OP_ADD : op_code_q + 1'b1)
                    : ev_dn ? ((op_code_q == OP_ADD) ? OP_LAST : op_code_q - 1'b1)
                    : op_code_q;
          state_d = ev_next ? ENTER_B : SEL_OP;
        end
        REQ: begin
          if (calc_valid_q && calc_ready) begin
            calc_valid_d = 1'b0;
            state_d      = WAIT;
          end
        end
        WAIT: begin
          if (res_valid) begin
            result_d = res_bcd;
            state_d  = SHOW;
          end
        end
        SHOW: begin
          if (ev_op) begin
            operand_a_d = result_q;
            entry_d     = '0;
            digit_sel_d = '0;
            state_d     = SEL_OP;
          end
        end
        default: state_d = ENTER_A;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ENTER_A;
      entry_q      <= '0;
      operand_a_q  <= '0;
      operand_b_q  <= '0;
      result_q     <= '0;
      disp_q       <= '0;
      op_code_q    <= OP_ADD;
      digit_sel_q  <= '0;
      calc_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      entry_q      <= entry_d;
      operand_a_q  <= operand_a_d;
      operand_b_q  <= operand_b_d;
      result_q     <= result_d;
      disp_q       <= disp_d;
      op_code_q    <= op_code_d;
      digit_sel_q  <= digit_sel_d;
      calc_valid_q <= calc_valid_d;
    end
  end
  assign calc_valid = calc_valid_q;
  assign operand_a  = operand_a_q;
  assign operand_b  = operand_b_q;
  assign op_code    = op_code_q;
  assign disp_bcd   = disp_q;
  assign digit_sel  = digit_sel_q;
  assign state_o    = state_q;
endmodule

// File: tb/tb_calc_key_entry.sv
// tb_calc_key_entry: directed and random checks of calc_key_entry against a digit-array reference model
module tb_calc_key_entry;
  localparam int D = 4;
  localparam int S_EA = 0, S_OP = 1, S_EB = 2, S_REQ = 3, S_WAIT = 4, S_SHOW = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic up_pulse = 0, down_pulse = 0, next_pulse = 0, op_pulse = 0, eq_pulse = 0, clr_pulse = 0;
  logic calc_ready = 0, res_valid = 0;
  logic [15:0] res_bcd = '0;
  logic calc_valid;
  logic [15:0] operand_a, operand_b, disp_bcd;
  logic [1:0] op_code;
  logic [1:0] digit_sel;
  logic [2:0] state_o;
  int n_tests = 0;
  int n_fail = 0;
  int m_state, m_sel, m_op;
  int m_e[D], m_a[D], m_b[D], m_r[D];
  bit m_valid;
  logic [15:0] m_disp;

  calc_key_entry #(.DIGITS(D), .OPS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_pulse(up_pulse), .down_pulse(down_pulse), .next_pulse(next_pulse),
    .op_pulse(op_pulse), .eq_pulse(eq_pulse), .clr_pulse(clr_pulse),
    .calc_valid(calc_valid), .calc_ready(calc_ready),
    .operand_a(operand_a), .operand_b(operand_b), .op_code(op_code),
    .res_valid(res_valid), .res_bcd(res_bcd),
    .disp_bcd(disp_bcd), .digit_sel(digit_sel), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pack(input int d[D]);
    logic [15:0] p = '0;
    for (int i = 0; i < D; i++) p = p | (16'(d[i]) << (4 * i));
    return p;
  endfunction

  task automatic model_reset();
    m_state = S_EA; m_sel = 0; m_op = 0; m_valid = 0; m_disp = '0;
    for (int i = 0; i < D; i++) begin m_e[i] = 0; m_a[i] = 0; m_b[i] = 0; m_r[i] = 0; end
  endtask

  task automatic model_edge(input bit u, dn, nx, o, e, c, rdy, rv, input logic [15:0] rb);
    logic [15:0] src;
    src = (m_state == S_EA || m_state == S_EB) ? pack(m_e) : (m_state == S_OP) ? pack(m_a)
        : (m_state == S_REQ || m_state == S_WAIT) ? pack(m_b) : pack(m_r);
    if (c) model_reset();
    else begin
      bit ee = e, eo = o && !e, en = nx && !o && !e;
      bit eu = u && !nx && !o && !e, ed = dn && !u && !nx && !o && !e;
      if (m_state == S_EA || m_state == S_EB) begin
        if (eu) m_e[m_sel] = (m_e[m_sel] + 1) % 10;
        if (ed) m_e[m_sel] = (m_e[m_sel] + 9) % 10;
        if (en) m_sel = (m_sel + 1) % D;
        if (eo && m_state == S_EA) begin
          m_a = m_e; m_state = S_OP; m_sel = 0;
          for (int i = 0; i < D; i++) m_e[i] = 0;
        end else if (ee && m_state == S_EB) begin
          m_b = m_e; m_valid = 1; m_state = S_REQ;
        end
      end else if (m_state == S_OP) begin
        if (eu) m_op = (m_op + 1) % 4;
        if (ed) m_op = (m_op + 3) % 4;
        if (en) m_state = S_EB;
      end else if (m_state == S_REQ) begin
        if (rdy) begin m_valid = 0; m_state = S_WAIT; end
      end else if (m_state == S_WAIT) begin
        if (rv) begin
          for (int i = 0; i < D; i++) m_r[i] = int'(rb[4*i +: 4]);
          m_state = S_SHOW;
        end
      end else if (m_state == S_SHOW && eo) begin
        m_a = m_r; m_state = S_OP; m_sel = 0;
        for (int i = 0; i < D; i++) m_e[i] = 0;
      end
    end
    m_disp = src;
  endtask

  task automatic compare(input string tag);
    check({tag, ":state"}, 32'(state_o), 32'(m_state));
    check({tag, ":valid"}, 32'(calc_valid), 32'(m_valid));
    check({tag, ":a"}, 32'(operand_a), 32'(pack(m_a)));
    check({tag, ":b"}, 32'(operand_b), 32'(pack(m_b)));
    check({tag, ":op"}, 32'(op_code), 32'(m_op));
    check({tag, ":sel"}, 32'(digit_sel), 32'(m_sel));
    check({tag, ":disp"}, 32'(disp_bcd), 32'(m_disp));
  endtask

  task automatic step(input string tag, input bit u, dn, nx, o, e, c, rdy, rv, input logic [15:0] rb);
    up_pulse = u; down_pulse = dn; next_pulse = nx; op_pulse = o; eq_pulse = e; clr_pulse = c;
    calc_ready = rdy; res_valid = rv; res_bcd = rb;
    @(posedge clk);
    model_edge(u, dn, nx, o, e, c, rdy, rv, rb);
    #1;
    compare(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0, 0, 0, 0, '0);
  endtask

  initial begin
    model_reset();
    #12;
    check("rst:state", 32'(state_o), 0);
    check("rst:valid", 32'(calc_valid), 0);
    check("rst:disp", 32'(disp_bcd), 0);
    check("rst:a", 32'(operand_a), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) step("wrap_up", 1, 0, 0, 0, 0, 0, 0, 0, '0);
    step("wrap_nx", 0, 0, 1, 0, 0, 0, 0, 0, '0);
    step("wrap_dn", 0, 1, 0, 0, 0, 0, 0, 0, '0);
    step("wrap_op", 0, 0, 0, 1, 0, 0, 0, 0, '0);
    check("wrap:a", 32'(operand_a), 32'h0093);
    check("wrap:state", 32'(state_o), S_OP);
    idle("wrap_idle", 1);
    check("wrap:disp", 32'(disp_bcd), 32'h0093);
    step("full_clr", 0, 0, 0, 0, 0, 1, 0, 0, '0);
    step("full_a", 1, 0, 0, 0, 0, 0, 0, 0, '0);
    step("full_a", 1, 0, 0, 0, 0, 0, 0, 0, '0);
    step("full_a", 0, 0, 1, 0, 0, 0, 0, 0, '0);
    step("full_a", 1, 0, 0, 0, 0, 0, 0, 0, '0);
    step("full_op", 0, 0, 0, 1, 0, 0, 0, 0, '0);
    step("full_sel", 1, 0, 0, 0, 0, 0, 0, 0, '0);
    step("full_sel", 1, 0, 0, 0, 0, 0, 0, 0, '0);
    check("full:op_code", 32'(op_code), 2);
    step("full_nx", 0, 0, 1, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) step("full_b", 1, 0, 0, 0, 0, 0, 0, 0, '0);
    step("full_eq", 0, 0, 0, 0, 1, 0, 1, 0, '0);
    check("full:valid", 32'(calc_valid), 1);
    check("full:b", 32'(operand_b), 32'h0003);
    for (int i = 0; i < 5; i++) begin
      idle("full_hold", 1);
      check("hold:valid", 32'(calc_valid), 1);
      check("hold:a", 32'(operand_a), 32'h0012);
      check("hold:b", 32'(operand_b), 32'h0003);
    end
    step("full_rdy", 0, 0, 0, 0, 0, 0, 1, 0, '0);
    check("full:valid_drop", 32'(calc_valid), 0);
    check("full:wait", 32'(state_o), S_WAIT);
    step("full_res", 0, 0, 0, 0, 0, 0, 0, 1, 16'h0036);
    idle("full_idle", 1);
    check("full:disp", 32'(disp_bcd), 32'h0036);
    check("full:show", 32'(state_o), S_SHOW);
    step("chain_op", 0, 0, 0, 1, 0, 0, 0, 0, '0);
    check("chain:a", 32'(operand_a), 32'h0036);
    check("chain:state", 32'(state_o), S_OP);
    step("chain_rv", 0, 0, 0, 0, 0, 0, 0, 1, 16'h9999);
    check("chain:state2", 32'(state_o), S_OP);
    check("chain:a2", 32'(operand_a), 32'h0036);
    step("pri_nx", 0, 0, 1, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) step("pri_up", 1, 0, 0, 0, 0, 0, 0, 0, '0);
    idle("pri_idle", 1);
    check("pri:entry5", 32'(disp_bcd), 32'h0005);
    step("pri_clr", 1, 0, 1, 0, 0, 1, 0, 0, '0);
    check("pri:state", 32'(state_o), S_EA);
    idle("pri_idle", 1);
    check("pri:disp0", 32'(disp_bcd), 0);
    step("pri_upnx", 1, 0, 1, 0, 0, 0, 0, 0, '0);
    check("pri:sel", 32'(digit_sel), 1);
    idle("pri_idle", 1);
    check("pri:entry0", 32'(disp_bcd), 0);
    step("ab_op", 0, 0, 0, 1, 0, 0, 0, 0, '0);
    step("ab_nx", 0, 0, 1, 0, 0, 0, 0, 0, '0);
    step("ab_eq", 0, 0, 0, 0, 1, 0, 0, 0, '0);
    step("ab_rdy", 0, 0, 0, 0, 0, 0, 1, 0, '0);
    step("ab_clr", 0, 0, 0, 0, 0, 1, 0, 0, '0);
    step("ab_rv", 0, 0, 0, 0, 0, 0, 0, 1, 16'h1234);
    check("abort:state", 32'(state_o), S_EA);
    idle("ab_idle", 1);
    check("abort:disp", 32'(disp_bcd), 0);
    step("ar_a", 1, 0, 0, 0, 0, 0, 0, 0, '0);
    step("ar_op", 0, 0, 0, 1, 0, 0, 0, 0, '0);
    step("ar_nx", 0, 0, 1, 0, 0, 0, 0, 0, '0);
    step("ar_b", 1, 0, 0, 0, 0, 0, 0, 0, '0);
    step("ar_eq", 0, 0, 0, 0, 1, 0, 0, 0, '0);
    idle("ar_idle", 2);
    #2 rst_n = 1'b0;
    #1;
    check("arst:valid", 32'(calc_valid), 0);
    check("arst:state", 32'(state_o), 0);
    check("arst:disp", 32'(disp_bcd), 0);
    check("arst:a", 32'(operand_a), 0);
    check("arst:b", 32'(operand_b), 0);
    model_reset();
    @(posedge clk); #1;
    compare("arst_hold");
    #2 rst_n = 1'b1;
    idle("arst_rel", 1);
    for (int n = 0; n < 2000; n++) begin
      logic [15:0] rb;
      for (int i = 0; i < D; i++) rb[4*i +: 4] = 4'($urandom_range(0, 9));
      step("rand", $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 60) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, rb);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/calc_key_entry.md
Name: calc_key_entry

Overview:
- Consumes single-cycle pulses from the per-button debouncers and builds calculator operands digit by digit in BCD.
- Selects the operation and hands operand A, operand B and the op code to the ALU over a valid/ready handshake.
- Captures the ALU result and drives the display digits.
- Sits between the button debouncers and the ALU/seven-segment display path.

Parameters:
- DIGITS, 4, number of BCD digits per operand (2..8).
- OPS, 4, number of selectable operations; op_code is 2 bits.

Ports:
- clk  in  1  system clock (100 MHz)
- rst_n  in  1  asynchronous active-low reset
- up_pulse  in  1  debounced 1-cycle pulse: increment
- down_pulse  in  1  debounced 1-cycle pulse: decrement
- next_pulse  in  1  debounced 1-cycle pulse: next digit / confirm op
- op_pulse  in  1  debounced 1-cycle pulse: finish A, choose op
- eq_pulse  in  1  debounced 1-cycle pulse: finish B, compute
- clr_pulse  in  1  debounced 1-cycle pulse: clear all
- calc_valid  out  1  operands/op_code valid to ALU
- calc_ready  in  1  ALU accepts request
- operand_a  out  4*DIGITS  BCD operand A
- operand_b  out  4*DIGITS  BCD operand B
- op_code  out  2  0 add, 1 sub, 2 mul, 3 div
- res_valid  in  1  ALU result strobe
- res_bcd  in  4*DIGITS  ALU result, BCD
- disp_bcd  out  4*DIGITS  digits to display
- digit_sel  out  log2(DIGITS)  digit being edited (for blink)
- state_o  out  3  current state, for LEDs/debug

Behaviour:
Reset (async, rst_n low):
- State ENTER_A; entry, operand_a, operand_b, result all 0; op_code 0; digit_sel 0; calc_valid 0.
- Reset mid-handshake drops calc_valid immediately.

Events and timing:
- All state and register updates occur on posedge clk.
- Edits are visible on outputs the next cycle.
- One event per cycle, priority clr > eq > op > next > up > down; lower-priority pulses in the same cycle are discarded.
- An input held high counts as one event per cycle.
- Pulses not listed for the current state are ignored.

States:
- ENTER_A:
  - up: entry[digit_sel] +1 BCD, 9 wraps to 0, no carry to other digits.
  - down: entry[digit_sel] -1, 0 wraps to 9.
  - next: digit_sel +1 mod DIGITS.
  - op: operand_a <= entry, entry <= 0, digit_sel <= 0, go SEL_OP.
- SEL_OP:
  - up: op_code +1 mod OPS.
  - down: op_code -1 mod OPS.
  - next: go ENTER_B.
- ENTER_B:
  - up/down/next: same editing as ENTER_A.
  - eq: operand_b <= entry, calc_valid <= 1, go REQ.
- REQ:
  - calc_valid held, operands and op_code stable until calc_valid & calc_ready are both high in one cycle.
  - Then calc_valid <= 0, go WAIT.
  - calc_ready high in the same cycle eq fires has no effect; the handshake starts the cycle after.
- WAIT:
  - res_valid: result <= res_bcd, go SHOW.
  - res_valid in any other state is ignored.
- SHOW:
  - op: operand_a <= result, entry <= 0, digit_sel <= 0, go SEL_OP (chaining).
  - Other edit pulses ignored.
- clr in any state:
  - Go ENTER_A with full reset values; calc_valid drops next cycle.
  - A late res_valid after clr is ignored.

disp_bcd:
- ENTER_A/ENTER_B: entry.
- SEL_OP: operand_a.
- REQ/WAIT: operand_b.
- SHOW: result.
- Registered; updated the cycle after the source changes.

Decomposition:
- calc_pkg:
  - State enum: ENTER_A=0, SEL_OP=1, ENTER_B=2, REQ=3, WAIT=4, SHOW=5.
  - Op code constants OP_ADD/OP_SUB/OP_MUL/OP_DIV.
  - BCD digit width constant 4.
- Sub-module bcd_digit_step: combinational single-digit inc/dec with 9<->0 wrap. Instantiate DIGITS times, or once on the selected digit.

Test Plan:
- Reset: assert rst_n=0 mid-REQ -> calc_valid=0, state_o=0, disp_bcd=0, all operands 0 asynchronously.
- Entry wrap: DIGITS=4; up x3, next, down x1, op -> operand_a=16'h0093 (digit0=3, digit1=9), state SEL_OP, disp_bcd=16'h0093.
- Full op: A=0012, op up x2 (op_code=2), next, B=0003, eq -> calc_valid=1 with operand_b=16'h0003.
  - Hold calc_ready=0 for 5 cycles -> calc_valid and operands stable.
  - calc_ready=1 -> calc_valid=0 next cycle.
  - res_valid with res_bcd=16'h0036 -> disp_bcd=16'h0036 in SHOW.
- Priority: up_pulse and next_pulse and clr_pulse together in ENTER_B with entry 0005 -> ENTER_A, entry 0; without clr, same cycle up+next -> only digit_sel advances.
- Chaining: in SHOW with result 0036, op -> operand_a=16'h0036, state SEL_OP; res_valid pulse in SEL_OP -> no change.
- Abort: clr in WAIT, then res_valid=1 res_bcd=16'h1234 -> state stays ENTER_A, disp_bcd=0.
